// File: rtl/msg_block_builder.sv
// rtl/msg_block_builder.sv - debounced byte loader that builds one padded SHA-512 block
// Three raw buttons feed sync/debounce/edge stages; the FSM collects bytes, pads, then offers the block.
module msg_block_builder #(
   parameter int DEB_CYCLES = 1250000,
   parameter int MAX_BYTES  = 111
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    byte_in,
   input  logic          load_btn,
   input  logic          go_btn,
   input  logic          clr_btn,
   input  logic          block_ready,
   output logic [1023:0] block,
   output logic          block_valid,
   output logic [6:0]    byte_count,
   output logic          overflow,
   output logic          done
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {COLLECT, PAD, OFFER, DONE} state_t;

   logic [2:0] btn_raw;
   logic [2:0] pulse;
   logic       load_p, go_p, clr_p;

   assign btn_raw = {clr_btn, go_btn, load_btn};

   for (genvar b = 0; b < 3; b++) begin : g_deb
      logic          sync1_q, sync2_q, level_q, prev_q;
      logic [CW-1:0] cnt_q;

      // The count only runs while the synchronized sample disagrees with the level.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= btn_raw[b];
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            if (sync2_q == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign pulse[b] = level_q & ~prev_q;
   end

   assign load_p = pulse[0];
   assign go_p   = pulse[1];
   assign clr_p  = pulse[2];

   state_t          state_q, state_d;
   logic [1023:0]   block_q, block_d;
   logic [6:0]      count_q, count_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= COLLECT;
         block_q <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         block_q <= block_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      block_d = block_q;
      count_d = count_q;
      valid_d = valid_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      if (clr_p) begin
         state_d = COLLECT;
         block_d = '0;
         count_d = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (go_p) begin
                  state_d = PAD;
               end else if (load_p) begin
                  if (count_q < 7'(MAX_BYTES)) begin
                     block_d[10'd1023 - {count_q, 3'b000} -: 8] = byte_in;
                     count_d = count_q + 7'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
            PAD: begin
               // Terminator byte, zero fill up to byte 111, then the 128-bit bit length.
               for (int i = 0; i < 112; i++) begin
                  if (i == int'(count_q)) begin
                     block_d[1023 - 8*i -: 8] = 8'h80;
                  end else if (i > int'(count_q)) begin
                     block_d[1023 - 8*i -: 8] = 8'h00;
                  end
               end
               block_d[127:0] = {118'd0, count_q, 3'b000};
               valid_d = 1'b1;
               state_d = OFFER;
            end
            OFFER: begin
               if (valid_q && block_ready) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = COLLECT;
            end
         endcase
      end
   end

   assign block       = block_q;
   assign block_valid = valid_q;
   assign byte_count  = count_q;
   assign overflow    = ovf_q;
   assign done        = done_q;

endmodule
